// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: two-stage pixel compositor with strict layer priority,
// plus a frame counter and a scroll-offset accumulator.
// Optional feature macro: VGA_MIXER_BLINK_EN (per-layer blink on frame_cnt[5]).
module vga_layer_mixer #(
   parameter int unsigned NUM_LAYERS = 4,
   parameter int unsigned COLOR_BITS = 1,
   parameter int unsigned SCROLL_W   = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  valid,
   input  logic                                  hsync_in,
   input  logic                                  vsync_in,
   input  logic                                  newframe,
   input  logic [2:0]                            y_lsb,
   input  logic [NUM_LAYERS-1:0]                 layer_hit,
   input  logic [NUM_LAYERS-1:0]                 layer_en,
   input  logic [2*NUM_LAYERS-1:0]               layer_mode,
   input  logic [3*COLOR_BITS*NUM_LAYERS-1:0]    layer_color,
   input  logic [NUM_LAYERS-1:0]                 layer_blink,
   input  logic                                  scroll_run,
   input  logic [3:0]                            scroll_step,
   input  logic                                  scroll_clr,
   output logic [COLOR_BITS-1:0]                 r,
   output logic [COLOR_BITS-1:0]                 g,
   output logic [COLOR_BITS-1:0]                 b,
   output logic                                  hsync_out,
   output logic                                  vsync_out,
   output logic                                  hit_any,
   output logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0] winner,
   output logic [8:0]                            frame_cnt,
   output logic [SCROLL_W-1:0]                   scroll
);

   localparam int unsigned WIN_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam int unsigned PIX_W = 3 * COLOR_BITS;

   logic                           r_valid1;
   logic                           r_hs1;
   logic                           r_vs1;
   logic [2:0]                     r_y1;
   logic [NUM_LAYERS-1:0]          r_act1;
   logic [2*NUM_LAYERS-1:0]        r_mode1;
   logic [PIX_W*NUM_LAYERS-1:0]    r_color1;

   logic [PIX_W-1:0]               r_pix;
   logic                           r_hit_any;
   logic [WIN_W-1:0]               r_win;
   logic                           r_hs2;
   logic                           r_vs2;
   logic [8:0]                     r_frame_cnt;
   logic [SCROLL_W-1:0]            r_scroll;

   logic [NUM_LAYERS-1:0]          w_act;
   logic                           w_rain_r;
   logic                           w_rain_g;
   logic                           w_rain_b;
   logic [PIX_W-1:0]               w_rain;
   logic [PIX_W-1:0]               w_rot;
   logic [PIX_W-1:0]               w_pix;
   logic [WIN_W-1:0]               w_win;

`ifdef VGA_MIXER_BLINK_EN
   // Blinking layers are hidden during the upper half of each 64-frame period
   assign w_act = layer_hit & layer_en & ~(layer_blink & {NUM_LAYERS{r_frame_cnt[5]}});
`else
   logic w_unused_blink;
   assign w_act          = layer_hit & layer_en;
   assign w_unused_blink = ^layer_blink;
`endif

   // Stage 1: register video controls and qualified layer hits
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid1 <= 1'b0;
         r_hs1    <= 1'b0;
         r_vs1    <= 1'b0;
         r_y1     <= 3'd0;
         r_act1   <= '0;
         r_mode1  <= '0;
         r_color1 <= '0;
      end else begin
         r_valid1 <= valid;
         r_hs1    <= hsync_in;
         r_vs1    <= vsync_in;
         r_y1     <= y_lsb;
         r_act1   <= w_act;
         r_mode1  <= layer_mode;
         r_color1 <= layer_color;
      end
   end

   // Rainbow band colour selected by the low row bits
   always_comb begin
      w_rain_r = 1'b0;
      w_rain_g = 1'b0;
      w_rain_b = 1'b0;
      case (r_y1)
         3'd0:       begin w_rain_r = 1'b1; w_rain_b = 1'b1; end
         3'd1, 3'd2: begin w_rain_r = 1'b1; end
         3'd3, 3'd4: begin w_rain_r = 1'b1; w_rain_g = 1'b1; end
         3'd5:       begin w_rain_g = 1'b1; end
         default:    begin w_rain_g = 1'b1; w_rain_b = 1'b1; end
      endcase
   end

   assign w_rain = {{COLOR_BITS{w_rain_r}}, {COLOR_BITS{w_rain_g}}, {COLOR_BITS{w_rain_b}}};
   assign w_rot  = {{COLOR_BITS{w_rain_g}}, {COLOR_BITS{w_rain_b}}, {COLOR_BITS{w_rain_r}}};

   // Composite: walk layers low to high so later hits override (or invert) earlier ones
   always_comb begin
      w_pix = '0;
      w_win = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (r_act1[i]) begin
            case (r_mode1[2*i +: 2])
               2'b00:   w_pix = r_color1[PIX_W*i +: PIX_W];
               2'b01:   w_pix = w_rain;
               2'b10:   w_pix = w_rot;
               default: w_pix = ~w_pix;
            endcase
            w_win = WIN_W'(i);
         end
      end
   end

   // Stage 2: registered pixel, blanked outside active video, with aligned syncs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pix     <= '0;
         r_hit_any <= 1'b0;
         r_win     <= '0;
         r_hs2     <= 1'b0;
         r_vs2     <= 1'b0;
      end else begin
         r_pix     <= r_valid1 ? w_pix : '0;
         r_hit_any <= |r_act1;
         r_win     <= w_win;
         r_hs2     <= r_hs1;
         r_vs2     <= r_vs1;
      end
   end

   // Frame counter, wraps naturally at 512
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= 9'd0;
      end else if (newframe) begin
         r_frame_cnt <= r_frame_cnt + 9'd1;
      end
   end

   // Scroll accumulator: clear beats advance
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scroll <= '0;
      end else if (scroll_clr) begin
         r_scroll <= '0;
      end else if (newframe && scroll_run) begin
         r_scroll <= r_scroll + SCROLL_W'(scroll_step);
      end
   end

   assign r         = r_pix[PIX_W-1 -: COLOR_BITS];
   assign g         = r_pix[2*COLOR_BITS-1 -: COLOR_BITS];
   assign b         = r_pix[COLOR_BITS-1:0];
   assign hit_any   = r_hit_any;
   assign winner    = r_win;
   assign hsync_out = r_hs2;
   assign vsync_out = r_vs2;
   assign frame_cnt = r_frame_cnt;
   assign scroll    = r_scroll;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Testbench for vga_layer_mixer (default parameters): directed literal checks
// plus randomized stimulus against a behavioural reference model.
module tb_vga_layer_mixer;

`ifdef VGA_MIXER_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   typedef struct packed {
      logic [2:0] rgb;
      logic       any;
      logic [1:0] win;
      logic       hs;
      logic       vs;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        valid;
   logic        hsync_in;
   logic        vsync_in;
   logic        newframe;
   logic [2:0]  y_lsb;
   logic [3:0]  layer_hit;
   logic [3:0]  layer_en;
   logic [7:0]  layer_mode;
   logic [11:0] layer_color;
   logic [3:0]  layer_blink;
   logic        scroll_run;
   logic [3:0]  scroll_step;
   logic        scroll_clr;
   logic        r;
   logic        g;
   logic        b;
   logic        hsync_out;
   logic        vsync_out;
   logic        hit_any;
   logic [1:0]  winner;
   logic [8:0]  frame_cnt;
   logic [7:0]  scroll;

   int total;
   int bad;
   bit chk_en;

   exp_t       m_pend;
   exp_t       m_out;
   logic [8:0] m_fc;
   logic [7:0] m_sc;

   logic [2:0] rain_tab [8] = '{3'b101, 3'b100, 3'b100, 3'b110, 3'b110, 3'b010, 3'b011, 3'b011};
   logic [2:0] rot_tab  [8] = '{3'b011, 3'b001, 3'b001, 3'b101, 3'b101, 3'b100, 3'b110, 3'b110};

   vga_layer_mixer dut (
      .clk         (clk),
      .rst         (rst),
      .valid       (valid),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .newframe    (newframe),
      .y_lsb       (y_lsb),
      .layer_hit   (layer_hit),
      .layer_en    (layer_en),
      .layer_mode  (layer_mode),
      .layer_color (layer_color),
      .layer_blink (layer_blink),
      .scroll_run  (scroll_run),
      .scroll_step (scroll_step),
      .scroll_clr  (scroll_clr),
      .r           (r),
      .g           (g),
      .b           (b),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .hit_any     (hit_any),
      .winner      (winner),
      .frame_cnt   (frame_cnt),
      .scroll      (scroll)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Pixel result from the priority rules: the topmost non-invert hit sets the
   // base colour, and every invert layer stacked above it flips it once.
   function automatic exp_t model_pix(input logic v, input logic hs, input logic vs,
                                      input logic [2:0] y, input logic [3:0] hit,
                                      input logic [3:0] en, input logic [3:0] blink,
                                      input logic [7:0] mode, input logic [11:0] col,
                                      input logic [8:0] fc);
      exp_t       e;
      logic [3:0] act;
      int         top;
      int         base;
      int         ninv;
      logic [2:0] c;
      logic [2:0] rn;
      act = hit & en;
      if (BLINK && fc[5]) act = act & ~blink;
      top  = -1;
      base = -1;
      ninv = 0;
      for (int i = 0; i < 4; i++) begin
         if (act[i]) top = i;
         if (act[i] && mode[2*i +: 2] != 2'b11) base = i;
      end
      for (int i = 0; i < 4; i++) if (act[i] && i > base) ninv++;
      rn = rain_tab[y];
      if (base < 0) c = 3'b000;
      else begin
         case (mode[2*base +: 2])
            2'b00:   c = col[3*base +: 3];
            2'b01:   c = rn;
            default: c = {rn[1], rn[0], rn[2]};
         endcase
      end
      if (ninv % 2 == 1) c = ~c;
      e.rgb = v ? c : 3'b000;
      e.any = |act;
      e.win = (top < 0) ? 2'd0 : 2'(top);
      e.hs  = hs;
      e.vs  = vs;
      return e;
   endfunction

   // Reference model: two-deep pixel delay and the two frame-rate counters
   always @(posedge clk) begin
      if (rst) begin
         m_pend <= '0;
         m_out  <= '0;
         m_fc   <= 9'd0;
         m_sc   <= 8'd0;
      end else begin
         m_out  <= m_pend;
         m_pend <= model_pix(valid, hsync_in, vsync_in, y_lsb, layer_hit, layer_en,
                             layer_blink, layer_mode, layer_color, m_fc);
         if (newframe) m_fc <= m_fc + 9'd1;
         if (scroll_clr) m_sc <= 8'd0;
         else if (newframe && scroll_run) m_sc <= m_sc + {4'd0, scroll_step};
      end
   end

   // Compare process: every cycle against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rgb",       {29'd0, r, g, b},   {29'd0, m_out.rgb});
         chk("hit_any",   {31'd0, hit_any},   {31'd0, m_out.any});
         chk("winner",    {30'd0, winner},    {30'd0, m_out.win});
         chk("hsync_out", {31'd0, hsync_out}, {31'd0, m_out.hs});
         chk("vsync_out", {31'd0, vsync_out}, {31'd0, m_out.vs});
         chk("frame_cnt", {23'd0, frame_cnt}, {23'd0, m_fc});
         chk("scroll",    {24'd0, scroll},    {24'd0, m_sc});
      end
   end

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic frame_pulse();
      newframe = 1'b1;
      go();
      newframe = 1'b0;
      go();
   endtask

   initial begin
      clk = 1'b0; total = 0; bad = 0; chk_en = 1'b0;
      rst = 1'b1; valid = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; newframe = 1'b0;
      y_lsb = 3'd0; layer_hit = 4'h0; layer_en = 4'h0; layer_mode = 8'h00;
      layer_color = 12'h000; layer_blink = 4'h0; scroll_run = 1'b0;
      scroll_step = 4'd0; scroll_clr = 1'b0;

      // reset held for three clocks
      go();
      chk_en = 1'b1;
      go();
      go();
      chk("rst_rgb",   {29'd0, r, g, b}, 32'd0);
      chk("rst_win",   {30'd0, winner},  32'd0);
      chk("rst_frame", {23'd0, frame_cnt}, 32'd0);
      chk("rst_scroll",{24'd0, scroll},  32'd0);

      // first pixel after reset: latency of two clocks
      rst = 1'b0; valid = 1'b1; layer_hit = 4'b0001; layer_en = 4'hF;
      layer_mode = 8'h00; layer_color = 12'b000_000_000_110; hsync_in = 1'b1;
      go();
      chk("lat1_rgb", {29'd0, r, g, b}, 32'd0);
      hsync_in = 1'b0;
      go();
      chk("lat_rgb", {29'd0, r, g, b}, 32'b110);
      chk("lat_win", {30'd0, winner},  32'd0);
      chk("lat_any", {31'd0, hit_any}, 32'd1);
      chk("lat_hs",  {31'd0, hsync_out}, 32'd1);
      go();
      chk("lat_hs_fall", {31'd0, hsync_out}, 32'd0);

      // priority with invert on top, then top layer disabled
      layer_hit = 4'b1011; layer_mode = 8'b11_00_00_00;
      layer_color = 12'b000_000_100_110;
      go(); go();
      chk("inv_rgb", {29'd0, r, g, b}, 32'b011);
      chk("inv_win", {30'd0, winner},  32'd3);
      layer_en = 4'b0111;
      go(); go();
      chk("dis_rgb", {29'd0, r, g, b}, 32'b100);
      chk("dis_win", {30'd0, winner},  32'd1);

      // rainbow and rotated rainbow sweeps
      layer_en = 4'hF; layer_hit = 4'b0001;
      for (int m = 1; m <= 2; m++) begin
         layer_mode = 8'(m);
         for (int y = 0; y < 8; y++) begin
            y_lsb = 3'(y);
            go(); go();
            chk((m == 1) ? "rain" : "rot", {29'd0, r, g, b},
                {29'd0, (m == 1) ? rain_tab[y] : rot_tab[y]});
         end
      end

      // blanking keeps hit reporting
      layer_mode = 8'h00; valid = 1'b0; layer_hit = 4'hF;
      go(); go();
      chk("blank_rgb", {29'd0, r, g, b}, 32'd0);
      chk("blank_any", {31'd0, hit_any}, 32'd1);
      chk("blank_win", {30'd0, winner},  32'd3);

      // scroll accumulation, clear with frame, counter wrap
      scroll_step = 4'd5; scroll_run = 1'b1;
      for (int i = 0; i < 60; i++) frame_pulse();
      chk("scroll60", {24'd0, scroll},    32'd44);
      chk("frame60",  {23'd0, frame_cnt}, 32'd60);
      scroll_clr = 1'b1; newframe = 1'b1;
      go();
      scroll_clr = 1'b0; newframe = 1'b0;
      chk("clr_scroll", {24'd0, scroll},    32'd0);
      chk("clr_frame",  {23'd0, frame_cnt}, 32'd61);
      for (int i = 61; i < 512; i++) frame_pulse();
      chk("frame_wrap", {23'd0, frame_cnt}, 32'd0);

      // blink on layer 0
      valid = 1'b1; layer_hit = 4'b0001; layer_mode = 8'h00;
      layer_color = 12'b000_000_000_110; layer_blink = 4'b0001;
      go(); go();
      chk("blink_on_rgb", {29'd0, r, g, b}, 32'b110);
      for (int i = 0; i < 32; i++) frame_pulse();
      go(); go();
      chk("blink_off_any", {31'd0, hit_any}, BLINK ? 32'd0 : 32'd1);
      chk("blink_off_rgb", {29'd0, r, g, b}, BLINK ? 32'd0 : 32'b110);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         go();
         rst         = ($urandom_range(0, 299) == 0);
         valid       = ($urandom_range(0, 3) != 0);
         hsync_in    = 1'($urandom);
         vsync_in    = 1'($urandom);
         newframe    = ($urandom_range(0, 7) == 0);
         y_lsb       = 3'($urandom);
         layer_hit   = 4'($urandom);
         layer_en    = 4'($urandom) | 4'($urandom);
         layer_mode  = 8'($urandom);
         layer_color = 12'($urandom);
         layer_blink = 4'($urandom);
         scroll_run  = ($urandom_range(0, 3) != 0);
         scroll_step = 4'($urandom);
         scroll_clr  = ($urandom_range(0, 49) == 0);
      end
      rst = 1'b0;
      go(); go(); go();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_layer_mixer.md
# vga_layer_mixer

Parametrised pixel compositor for the Mojo VGA path. It merges `NUM_LAYERS` one-bit layer masks into a single RGB pixel using per-layer fixed-colour, rainbow, rotated-rainbow or invert modes with strict priority. It also maintains a frame counter and a scroll-offset accumulator that drive the scrolling fizz/buzz lines. It sits between the vga timing generator plus layer sources (character generator, bigword sprites) and the output pins, and delays hsync/vsync to match its pipeline.

## Interface
Parameters:
- `NUM_LAYERS`, default 4: number of layers; layer index NUM_LAYERS-1 has highest priority.
- `COLOR_BITS`, default 1: bits per colour channel.
- `SCROLL_W`, default 8: scroll accumulator width.

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- `clk` in 1: pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `valid` in 1: active video, aligned with the layer inputs.
- `hsync_in`, `vsync_in` in 1 each: syncs from the timing generator.
- `newframe` in 1: one-cycle pulse at frame start.
- `y_lsb` in 3: y[2:0]; selects the rainbow band.
- `layer_hit` in NUM_LAYERS: per-layer pixel-on.
- `layer_en` in NUM_LAYERS: layer enable; a disabled layer never wins.
- `layer_mode` in 2*NUM_LAYERS: per-layer mode, bits [2i+1:2i].
- `layer_color` in 3*COLOR_BITS*NUM_LAYERS: per-layer {r,g,b}, slice i.
- `layer_blink` in NUM_LAYERS: per-layer blink request (only used under the blink macro).
- `scroll_run` in 1: enables scroll advance.
- `scroll_step` in 4: increment added per frame.
- `scroll_clr` in 1: clears the scroll accumulator.
- `r`, `g`, `b` out COLOR_BITS each: registered pixel.
- `hsync_out`, `vsync_out` out 1 each: syncs delayed to match the pixel.
- `hit_any` out 1: at least one enabled layer hit, aligned with the pixel.
- `winner` out clog2(NUM_LAYERS) (minimum 1): index of the winning layer; 0 when none.
- `frame_cnt` out 9: frame counter.
- `scroll` out SCROLL_W: scroll offset.

## Operation
- **Rainbow colour from `y_lsb`**
  - 0: r+b
  - 1, 2: r
  - 3, 4: r+g
  - 5: g
  - 6, 7: g+b
  - An active channel is all-ones (COLOR_BITS wide); an inactive channel is 0.
- **Composite**: start from background 0, then walk the layers from 0 up to NUM_LAYERS-1. Each layer with `hit & en` replaces the running colour according to its mode:
  - 00 fixed: use `layer_color[i]`.
  - 01 rainbow: use the rainbow colour.
  - 10 rotated rainbow: {r,g,b} = {rain_g, rain_b, rain_r}.
  - 11 invert: bitwise NOT of the running colour accumulated from lower layers.
- **Winner**: `winner` = highest index with `hit & en`.
- **Blanking**: when the delayed `valid` is low, `r`/`g`/`b` are 0. `hit_any` and `winner` are still reported.
- **Frame counter**: on `newframe`, `frame_cnt` increments by 1 and wraps 511→0.
- **Scroll accumulator**, priority order:
  1. `rst` sets `scroll` to 0.
  2. Otherwise `scroll_clr` sets it to 0.
  3. Otherwise, `newframe & scroll_run` adds zero-extended `scroll_step`, modulo 2^SCROLL_W.
  4. Otherwise it holds.
- **Simultaneous events**: `newframe` together with `scroll_clr` gives `scroll` = 0 while `frame_cnt` still increments.
- **Reset values**: `r`, `g`, `b`, `hsync_out`, `vsync_out`, `hit_any`, `winner`, `frame_cnt`, `scroll` are all 0. All internal pipeline registers clear.

## Timing
- **Stage 1** registers `valid`, syncs, `y_lsb`, `layer_hit & layer_en` (blink-masked under the macro), `layer_mode` and `layer_color`.
- **Stage 2** computes the composite from the stage-1 registers and registers the outputs.
- **Latency**: exactly 2 clocks from input to `r`/`g`/`b`/`hit_any`/`winner`/`hsync_out`/`vsync_out`. All of these stay mutually aligned.
- **Counters**: `frame_cnt` and `scroll` update on the clock edge where `newframe` is sampled, and are visible the next cycle. They are not pipelined.
- **Reset mid-frame**: outputs are 0 on the cycle after reset is asserted. After deassert, valid data appears 2 clocks after the first new input.
- **Throughput**: one pixel per clock, with no stalls.

## Configuration
- **`VGA_MIXER_BLINK_EN` defined**: a layer with `layer_blink[i]=1` is treated as not hit whenever `frame_cnt[5]=1`. The effect is 32 frames visible, 32 frames hidden. Masking is applied before stage 1, so `hit_any` and `winner` reflect it.
- **Not defined**: `layer_blink` is ignored, and the masking logic is not synthesised.

## Test plan
- **Reset and latency**: hold `rst` for 3 clocks, then drive `valid=1`, `layer_hit=4'b0001`, `layer_en=4'hF`, mode0=00, colour0=3'b110.
  - Outputs are 0 during reset.
  - r=1, g=1, b=0, `winner`=0, `hit_any`=1 exactly 2 clocks after the first driven cycle.
  - `hsync_out` mirrors `hsync_in` delayed 2 clocks.
- **Priority, invert and disable**:
  - `layer_hit=4'b1011`, mode3=11, mode1=00, colour1=3'b100 → output 3'b011, `winner`=3.
  - Set `layer_en[3]=0` → output 3'b100, `winner`=1.
- **Rainbow sweep**: mode0=01, sweep `y_lsb` 0..7 → rgb sequence 101, 100, 100, 110, 110, 010, 011, 011.
  - Repeat with mode0=10 → each value rotated as {g,b,r}, e.g. y=0 gives 011.
- **Scroll**:
  - `scroll_step`=5, `scroll_run`=1, 60 `newframe` pulses with SCROLL_W=8 → `scroll`=44 (300 mod 256), `frame_cnt`=60.
  - `scroll_clr` coincident with `newframe` → `scroll`=0, `frame_cnt`=61.
  - 512 total frames → `frame_cnt` wraps to 0.
- **Blanking**: `valid=0` with `layer_hit=4'hF` → rgb=0, `hit_any`=1, `winner`=3.
- **Blink (macro defined)**: `layer_blink[0]=1`, layer 0 hit.
  - Frames 0–31: visible.
  - Frames 32–63: rgb=0 and `hit_any`=0.
  - Without the macro: always visible.
